// File: rtl/comma_pkg.sv
// rtl/comma_pkg.sv - shared state encoding and default comma patterns
package comma_pkg;

  // Encoding 2'd3 is never produced; the FSM treats it as HUNT.
  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    CHECK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  localparam logic [9:0] K28_5_NEG = 10'h0FA;
  localparam logic [9:0] K28_5_POS = 10'h305;

endpackage

// File: rtl/comma_sync_fsm_if.sv
// rtl/comma_sync_fsm_if.sv - deserialiser-side bundle for the comma aligner
interface comma_sync_fsm_if #(
  parameter int SYMBOL_W = 10
);

  logic                align_en;
  logic                rx_polarity;
  logic [SYMBOL_W-1:0] data_window;
  logic [SYMBOL_W-1:0] sym_out;
  logic                sym_valid;
  logic                comma_pulse;
  logic                locked;
  logic [1:0]          state_dbg;

  modport master (
    output align_en, rx_polarity, data_window,
    input  sym_out, sym_valid, comma_pulse, locked, state_dbg
  );

  modport slave (
    input  align_en, rx_polarity, data_window,
    output sym_out, sym_valid, comma_pulse, locked, state_dbg
  );

endinterface

// File: rtl/comma_match.sv
// rtl/comma_match.sv - polarity correction and dual comma compare
module comma_match
  import comma_pkg::*;
#(
  parameter int                  SYMBOL_W = 10,
  parameter logic [SYMBOL_W-1:0] COMMA_A  = K28_5_NEG,
  parameter logic [SYMBOL_W-1:0] COMMA_B  = K28_5_POS
) (
  input  logic [SYMBOL_W-1:0] data_window,
  input  logic                rx_polarity,
  output logic [SYMBOL_W-1:0] w,
  output logic                match
);

  assign w     = data_window ^ {SYMBOL_W{rx_polarity}};
  assign match = (w == COMMA_A) || (w == COMMA_B);

endmodule

// File: rtl/comma_sync_fsm.sv
// rtl/comma_sync_fsm.sv - comma hunt / check / lock state machine
// Establishes a symbol boundary from repeated aligned commas and strobes aligned symbols in lock.
module comma_sync_fsm
  import comma_pkg::*;
#(
  parameter int                  SYMBOL_W    = 10,
  parameter logic [SYMBOL_W-1:0] COMMA_A     = K28_5_NEG,
  parameter logic [SYMBOL_W-1:0] COMMA_B     = K28_5_POS,
  parameter int                  LOCK_COMMAS = 4,
  parameter int                  LOSS_COUNT  = 3
) (
  input logic             clk,
  input logic             rst,
  comma_sync_fsm_if.slave bus
);

  localparam int BW = $clog2(SYMBOL_W);
  localparam int GW = $clog2(LOCK_COMMAS + 1);
  localparam int EW = $clog2(LOSS_COUNT + 1);
  localparam logic [GW-1:0] GOOD_MAX = GW'(LOCK_COMMAS);
  localparam logic [EW-1:0] ERR_MAX  = EW'(LOSS_COUNT);

  logic [SYMBOL_W-1:0] w;
  logic                match;

  comma_match #(
    .SYMBOL_W (SYMBOL_W),
    .COMMA_A  (COMMA_A),
    .COMMA_B  (COMMA_B)
  ) u_match (
    .data_window (bus.data_window),
    .rx_polarity (bus.rx_polarity),
    .w           (w),
    .match       (match)
  );

  state_t              state_q, state_d;
  logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]       good_q, good_d;
  logic [EW-1:0]       err_q, err_d;
  logic [SYMBOL_W-1:0] sym_out_q, sym_out_d;
  logic                sym_valid_q, sym_valid_d;
  logic                comma_q, comma_d;
  logic                locked_q, locked_d;

  logic                boundary;
  logic [BW-1:0]       bit_next;
  logic [GW-1:0]       good_inc;
  logic [EW-1:0]       err_inc;

  assign boundary = (bit_cnt_q == '0);
  assign bit_next = (bit_cnt_q == BW'(SYMBOL_W - 1)) ? '0 : bit_cnt_q + BW'(1);
  assign good_inc = (good_q == GOOD_MAX) ? good_q : good_q + GW'(1);
  assign err_inc  = (err_q == ERR_MAX) ? err_q : err_q + EW'(1);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_next;
    good_d      = good_q;
    err_d       = err_q;
    sym_out_d   = sym_out_q;
    sym_valid_d = 1'b0;
    comma_d     = 1'b0;
    locked_d    = locked_q;
    if (!bus.align_en) begin
      state_d   = HUNT;
      bit_cnt_d = '0;
      good_d    = '0;
      err_d     = '0;
      locked_d  = 1'b0;
    end else begin
      case (state_q)
        CHECK: begin
          if (match && boundary) begin
            good_d = good_inc;
            if (good_inc == GOOD_MAX) begin
              state_d  = LOCKED;
              err_d    = '0;
              locked_d = 1'b1;
            end
          end else if (match) begin
            bit_cnt_d = BW'(1);
            good_d    = GW'(1);
          end
        end
        LOCKED: begin
          if (boundary) begin
            sym_valid_d = 1'b1;
            sym_out_d   = w;
            comma_d     = match;
            if (match) err_d = '0;
          end else if (match) begin
            // Loss of lock keeps bit_cnt running; HUNT re-anchors on the next comma.
            if (err_inc == ERR_MAX) begin
              state_d  = HUNT;
              good_d   = '0;
              err_d    = '0;
              locked_d = 1'b0;
            end else begin
              err_d = err_inc;
            end
          end
        end
        default: begin
          state_d  = HUNT;
          locked_d = 1'b0;
          if (match) begin
            bit_cnt_d = BW'(1);
            good_d    = GW'(1);
            err_d     = '0;
            if (LOCK_COMMAS == 1) begin
              state_d  = LOCKED;
              locked_d = 1'b1;
            end else begin
              state_d = CHECK;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      bit_cnt_q   <= '0;
      good_q      <= '0;
      err_q       <= '0;
      sym_out_q   <= '0;
      sym_valid_q <= 1'b0;
      comma_q     <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      good_q      <= good_d;
      err_q       <= err_d;
      sym_out_q   <= sym_out_d;
      sym_valid_q <= sym_valid_d;
      comma_q     <= comma_d;
      locked_q    <= locked_d;
    end
  end

  assign bus.sym_out     = sym_out_q;
  assign bus.sym_valid   = sym_valid_q;
  assign bus.comma_pulse = comma_q;
  assign bus.locked      = locked_q;
  assign bus.state_dbg   = state_q;

endmodule

// File: tb/tb_comma_sync_fsm.sv
// tb/tb_comma_sync_fsm.sv - vector table, corner sequences and random run vs reference model
module tb_comma_sync_fsm;

  localparam int         W  = 10;
  localparam logic [9:0] CA = 10'h0FA;
  localparam logic [9:0] CB = 10'h305;
  localparam logic [9:0] DA = 10'h2AA;
  localparam int         LC = 4;
  localparam int         LL = 3;

  logic clk;
  logic rst = 1'b0;

  comma_sync_fsm_if #(.SYMBOL_W(W)) bus ();

  comma_sync_fsm #(
    .SYMBOL_W    (W),
    .COMMA_A     (CA),
    .COMMA_B     (CB),
    .LOCK_COMMAS (LC),
    .LOSS_COUNT  (LL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: mode 0/1/2 = hunting/checking/locked; boundary is the
  // distance in cycles from the last alignment point being a multiple of W.
  int         m_mode, m_anchor, m_good, m_err, m_cyc;
  logic [9:0] m_sym;
  bit         m_valid, m_comma, m_locked;

  task automatic model_reset();
    m_mode = 0; m_anchor = 0; m_good = 0; m_err = 0; m_cyc = 0;
    m_sym = '0; m_valid = 0; m_comma = 0; m_locked = 0;
  endtask

  task automatic model_step(input logic en, input logic pol, input logic [9:0] win);
    logic [9:0] w;
    bit         mt, bnd;
    w   = pol ? ~win : win;
    mt  = (w == CA) || (w == CB);
    bnd = ((m_cyc - m_anchor) % W) == 0;
    m_valid = 0;
    m_comma = 0;
    if (!en) begin
      m_mode = 0; m_good = 0; m_err = 0; m_locked = 0;
    end else if (m_mode == 0) begin
      if (mt) begin
        m_anchor = m_cyc; m_good = 1; m_err = 0;
        if (LC == 1) begin m_mode = 2; m_locked = 1; end
        else m_mode = 1;
      end
    end else if (m_mode == 1) begin
      if (mt && bnd) begin
        m_good++;
        if (m_good == LC) begin m_mode = 2; m_locked = 1; m_err = 0; end
      end else if (mt) begin
        m_anchor = m_cyc; m_good = 1;
      end
    end else begin
      if (bnd) begin
        m_valid = 1; m_sym = w; m_comma = mt;
        if (mt) m_err = 0;
      end else if (mt) begin
        m_err++;
        if (m_err == LL) begin m_mode = 0; m_good = 0; m_err = 0; m_locked = 0; end
      end
    end
    m_cyc++;
  endtask

  task automatic check_model();
    check("model.sym_valid", bus.sym_valid, m_valid);
    check("model.comma_pulse", bus.comma_pulse, m_comma);
    check("model.locked", bus.locked, m_locked);
    check("model.state_dbg", bus.state_dbg, m_mode);
    if (m_valid) check("model.sym_out", bus.sym_out, m_sym);
  endtask

  task automatic apply(input logic en, input logic pol, input logic [9:0] win);
    bus.align_en    = en;
    bus.rx_polarity = pol;
    bus.data_window = win;
    @(posedge clk);
    model_step(en, pol, win);
    #1;
    check_model();
  endtask

  function automatic logic [9:0] filler(input int i);
    return 10'h150 | 10'(i & 15);
  endfunction

  task automatic idle(input int n, input logic pol);
    for (int k = 0; k < n; k++) apply(1'b1, pol, filler(k));
  endtask

  task automatic lock_seq(input logic pol);
    for (int k = 0; k < LC; k++) begin
      if (k > 0) idle(W - 1, pol);
      if (k == LC - 1) check("lock_seq.pre_state", bus.state_dbg, 1);
      apply(1'b1, pol, CA);
    end
    check("lock_seq.locked", bus.locked, 1);
    check("lock_seq.state", bus.state_dbg, 2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    check("rst.sym_out", bus.sym_out, 0);
    check("rst.sym_valid", bus.sym_valid, 0);
    check("rst.comma_pulse", bus.comma_pulse, 0);
    check("rst.locked", bus.locked, 0);
    check("rst.state_dbg", bus.state_dbg, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  typedef struct {
    logic       en;
    logic       pol;
    logic [9:0] win;
    logic [1:0] st;
    logic       lk;
    logic       vl;
    logic       cp;
    logic [9:0] so;
  } vec_t;

  vec_t       tbl[80];
  logic       r_en, r_pol;
  logic [9:0] r_win;
  int         phase;

  initial begin
    bus.align_en    = 1'b1;
    bus.rx_polarity = 1'b0;
    bus.data_window = '0;
    #1;

    // Lock after four aligned commas, then alternating comma / 2AA symbols.
    for (int i = 0; i < 80; i++) begin
      bit bnd, cm;
      bnd = (i % 10) == 0;
      cm  = (i < 40) || ((i / 10) % 2 == 0);
      tbl[i].en  = 1'b1;
      tbl[i].pol = 1'b0;
      tbl[i].win = bnd ? (cm ? CA : DA) : filler(i);
      tbl[i].st  = (i >= 30) ? 2'd2 : 2'd1;
      tbl[i].lk  = (i >= 30);
      tbl[i].vl  = bnd && (i >= 40);
      tbl[i].cp  = bnd && (i >= 40) && cm;
      tbl[i].so  = (i < 40) ? 10'h000 : (((i / 10) % 2 == 0) ? CA : DA);
    end

    do_reset();
    for (int i = 0; i < 80; i++) begin
      apply(tbl[i].en, tbl[i].pol, tbl[i].win);
      check($sformatf("tbl[%0d].state", i), bus.state_dbg, tbl[i].st);
      check($sformatf("tbl[%0d].locked", i), bus.locked, tbl[i].lk);
      check($sformatf("tbl[%0d].valid", i), bus.sym_valid, tbl[i].vl);
      check($sformatf("tbl[%0d].comma", i), bus.comma_pulse, tbl[i].cp);
      check($sformatf("tbl[%0d].sym_out", i), bus.sym_out, tbl[i].so);
    end

    // Misaligned comma in CHECK restarts the count at one.
    do_reset();
    apply(1'b1, 1'b0, CA);
    idle(9, 1'b0);
    apply(1'b1, 1'b0, CA);
    idle(12, 1'b0);
    apply(1'b1, 1'b0, CA);
    check("realign.state0", bus.state_dbg, 1);
    idle(9, 1'b0);
    apply(1'b1, 1'b0, CA);
    check("realign.state1", bus.state_dbg, 1);
    idle(9, 1'b0);
    apply(1'b1, 1'b0, CA);
    check("realign.state2", bus.state_dbg, 1);
    idle(9, 1'b0);
    apply(1'b1, 1'b0, CA);
    check("realign.locked", bus.locked, 1);

    // Misaligned commas at +5; an aligned comma clears the error count.
    idle(4, 1'b0);
    apply(1'b1, 1'b0, CA);
    idle(9, 1'b0);
    apply(1'b1, 1'b0, CA);
    check("loss.hold1", bus.locked, 1);
    idle(4, 1'b0);
    apply(1'b1, 1'b0, CA);
    check("loss.aligned_pulse", bus.comma_pulse, 1);
    idle(4, 1'b0);
    apply(1'b1, 1'b0, CA);
    idle(9, 1'b0);
    apply(1'b1, 1'b0, CA);
    check("loss.hold2", bus.locked, 1);
    idle(9, 1'b0);
    apply(1'b1, 1'b0, CA);
    check("loss.locked", bus.locked, 0);
    check("loss.state", bus.state_dbg, 0);

    // Inverted line: 0FA on the wire is 305 after correction.
    do_reset();
    lock_seq(1'b1);
    idle(9, 1'b1);
    apply(1'b1, 1'b1, CA);
    check("pol.valid", bus.sym_valid, 1);
    check("pol.sym_out", bus.sym_out, CB);
    check("pol.comma", bus.comma_pulse, 1);

    apply(1'b0, 1'b1, filler(0));
    check("align_en.locked", bus.locked, 0);
    check("align_en.state", bus.state_dbg, 0);
    check("align_en.sym_hold", bus.sym_out, CB);

    lock_seq(1'b0);
    idle(4, 1'b0);
    do_reset();

    r_pol = 1'b0;
    phase = 0;
    for (int i = 0; i < 3000; i++) begin
      phase = (phase + 1) % W;
      if ($urandom_range(0, 99) < 2) phase = $urandom_range(0, W - 1);
      if ($urandom_range(0, 199) == 0) r_pol = ~r_pol;
      r_en = ($urandom_range(0, 299) != 0);
      if ((phase == 0 && $urandom_range(0, 99) < 90) || $urandom_range(0, 99) < 4)
        r_win = ($urandom_range(0, 1) ? CA : CB) ^ {10{r_pol}};
      else
        r_win = 10'($urandom);
      apply(r_en, r_pol, r_win);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
